// File: rtl/alu_muldiv_ctrl.sv
// MIPS ALU control decode plus an iterative unsigned multiply/divide sequencer with HI/LO.
// The divider datapath and DIV state are built only when ALU_MULDIV_DIV_EN is defined.
module alu_muldiv_ctrl #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       ALUOp,
   input  logic [5:0]       Funct,
   input  logic             valid,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [3:0]       ALUCtrl,
   output logic             illegal,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StMul  = 2'd1;
`ifdef ALU_MULDIV_DIV_EN
   localparam logic [1:0] StDiv  = 2'd2;
`endif
   localparam logic [1:0] StDone = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               start;

   always_comb begin
      ALUCtrl = 4'd15;
      case (ALUOp)
         3'b000: ALUCtrl = 4'd2;
         3'b001: ALUCtrl = 4'd3;
         3'b010: ALUCtrl = 4'd4;
         3'b011: ALUCtrl = 4'd5;
         3'b101: ALUCtrl = 4'd6;
         3'b100: begin
            case (Funct)
               6'b100100: ALUCtrl = 4'd0;
               6'b100101: ALUCtrl = 4'd1;
               6'b100000: ALUCtrl = 4'd2;
               6'b100010: ALUCtrl = 4'd3;
               6'b011000: ALUCtrl = 4'd7;
`ifdef ALU_MULDIV_DIV_EN
               6'b011010: ALUCtrl = 4'd8;
`endif
               6'b000000: ALUCtrl = 4'd9;
               6'b000001: ALUCtrl = 4'd10;
               default:   ALUCtrl = 4'd15;
            endcase
         end
         default: ALUCtrl = 4'd15;
      endcase
   end

   assign illegal = valid & (ALUCtrl == 4'd15);
   assign start   = valid & (state_q == StIdle) & ((ALUCtrl == 4'd7) | (ALUCtrl == 4'd8));
   assign busy    = (state_q != StIdle);
   assign done    = (state_q == StDone);
   assign stall   = busy | start;
   assign hi      = hi_q;
   assign lo      = lo_q;

   // Shift-add: acc holds {partial product, remaining multiplier bits}.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q & {WIDTH{acc_q[0]}}};
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
   end

`ifdef ALU_MULDIV_DIV_EN
   // Restoring division: acc holds {remainder, dividend bits shifting into quotient}.
   logic [WIDTH:0]     div_shift, div_diff;
   logic [2*WIDTH-1:0] div_next;

   always_comb begin
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      if (div_diff[WIDTH]) begin
         div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
         div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               cnt_d = '0;
`ifdef ALU_MULDIV_DIV_EN
               if (ALUCtrl == 4'd8) begin
                  if (op_b == '0) begin
                     state_d = StDone;
                     hi_d    = op_a;
                     lo_d    = '1;
                  end else begin
                     state_d = StDiv;
                     acc_d   = {{WIDTH{1'b0}}, op_a};
                     opnd_d  = op_b;
                  end
               end else
`endif
               begin
                  state_d = StMul;
                  acc_d   = {{WIDTH{1'b0}}, op_b};
                  opnd_d  = op_a;
               end
            end
         end
         StMul: begin
            acc_d = mul_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d      = StDone;
               {hi_d, lo_d} = mul_next;
            end
         end
`ifdef ALU_MULDIV_DIV_EN
         StDiv: begin
            acc_d = div_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d      = StDone;
               {hi_d, lo_d} = div_next;
            end
         end
`endif
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Bench for alu_muldiv_ctrl: randomized decode and mult/div runs against an arithmetic model,
// on an 8-bit and a 32-bit instance; expectations follow ALU_MULDIV_DIV_EN.
`timescale 1ns/1ps
module tb_alu_muldiv_ctrl;

`ifdef ALU_MULDIV_DIV_EN
   localparam bit DivEn = 1'b1;
`else
   localparam bit DivEn = 1'b0;
`endif
   localparam int W8 = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  alu_op = 3'b000;
   logic [5:0]  funct = 6'b000000;
   logic        valid8 = 1'b0, valid32 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [31:0] a32 = '0, b32 = '0;
   logic [3:0]  ctrl8, ctrl32;
   logic        ill8, stall8, busy8, done8, ill32, stall32, busy32, done32;
   logic [7:0]  hi8, lo8;
   logic [31:0] hi32, lo32;

   int          checks = 0;
   int          errs = 0;
   logic [7:0]  m8_hi = '0, m8_lo = '0;
   logic [31:0] m32_hi = '0, m32_lo = '0;
   logic [5:0]  flist [10] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b011000,
                               6'b011010, 6'b000000, 6'b000001, 6'b111111, 6'b000000};

   alu_muldiv_ctrl #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .ALUOp(alu_op), .Funct(funct), .valid(valid8),
      .op_a(a8), .op_b(b8), .ALUCtrl(ctrl8), .illegal(ill8), .stall(stall8),
      .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
   );

   alu_muldiv_ctrl #(.WIDTH(32)) u32 (
      .clk(clk), .rst_n(rst_n), .ALUOp(alu_op), .Funct(funct), .valid(valid32),
      .op_a(a32), .op_b(b32), .ALUCtrl(ctrl32), .illegal(ill32), .stall(stall32),
      .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] ref_ctrl(input logic [2:0] op, input logic [5:0] f);
      case (op)
         3'd0: return 4'd2;
         3'd1: return 4'd3;
         3'd2: return 4'd4;
         3'd3: return 4'd5;
         3'd5: return 4'd6;
         3'd4: begin
            case (f)
               6'b100100: return 4'd0;
               6'b100101: return 4'd1;
               6'b100000: return 4'd2;
               6'b100010: return 4'd3;
               6'b011000: return 4'd7;
               6'b011010: return DivEn ? 4'd8 : 4'd15;
               6'b000000: return 4'd9;
               6'b000001: return 4'd10;
               default:   return 4'd15;
            endcase
         end
         default: return 4'd15;
      endcase
   endfunction

   // One mult (is_div=0) or div on the 8-bit instance, checked cycle by cycle.
   task automatic run_op8(input bit is_div, input logic [7:0] a, input logic [7:0] b);
      logic [15:0] res;
      logic [3:0]  exp_ctrl;
      bit          starts;
      int          ncyc;
      if (!is_div) res = 16'(a) * 16'(b);
      else if (b == 8'd0) res = {a, 8'hFF};
      else res = {a % b, a / b};
      exp_ctrl = is_div ? (DivEn ? 4'd8 : 4'd15) : 4'd7;
      starts   = !is_div || DivEn;
      ncyc     = (is_div && b == 8'd0) ? 1 : W8 + 1;
      @(negedge clk);
      alu_op = 3'b100;
      funct  = is_div ? 6'b011010 : 6'b011000;
      a8     = a;
      b8     = b;
      valid8 = 1'b1;
      #1;
      checks++;
      if ({ctrl8, ill8, stall8, busy8} !== {exp_ctrl, !starts, starts, 1'b0})
         $display("FAIL issue a=%0d b=%0d div=%0d: ctrl/ill/stall/busy got %h/%b/%b/%b want %h/%b/%b/0",
                  a, b, is_div, ctrl8, ill8, stall8, busy8, exp_ctrl, !starts, starts);
      if ({ctrl8, ill8, stall8, busy8} !== {exp_ctrl, !starts, starts, 1'b0}) errs++;
      @(posedge clk);
      #1;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      if (!starts) begin
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({busy8, done8, stall8, hi8, lo8} !== {3'b000, m8_hi, m8_lo}) begin
               errs++;
               $display("FAIL nodiv cycle %0d: busy/done/stall/hi/lo got %b/%b/%b/%h/%h want 0/0/0/%h/%h",
                        k, busy8, done8, stall8, hi8, lo8, m8_hi, m8_lo);
            end
         end
         valid8 = 1'b0;
      end else begin
         for (int k = 1; k <= ncyc + 1; k++) begin
            @(negedge clk);
            if (k == ncyc) {m8_hi, m8_lo} = res;
            checks++;
            if ({busy8, done8, stall8, hi8, lo8} !== {k <= ncyc, k == ncyc, k <= ncyc, m8_hi, m8_lo}) begin
               errs++;
               $display("FAIL op a=%0d b=%0d div=%0d cycle %0d: busy/done/stall/hi/lo got %b/%b/%b/%h/%h want %b/%b/%b/%h/%h",
                        a, b, is_div, k, busy8, done8, stall8, hi8, lo8,
                        k <= ncyc, k == ncyc, k <= ncyc, m8_hi, m8_lo);
            end
            if (k == ncyc) valid8 = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      alu_op = 3'b000;
      #2;
      checks++;
      if ({busy8, done8, hi8, lo8, busy32, done32, hi32, lo32, ctrl8} !== {2'b00, 16'h0, 2'b00, 64'h0, 4'd2}) begin
         errs++;
         $display("FAIL reset: busy8/done8/hi8/lo8=%b/%b/%h/%h busy32/done32=%b/%b hi32/lo32=%h/%h ctrl=%0d want zeros, ctrl=2",
                  busy8, done8, hi8, lo8, busy32, done32, hi32, lo32, ctrl8);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_decode();
      logic [3:0] exp;
      for (int o = 0; o < 8; o++) begin
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            alu_op = 3'(o);
            funct  = (i == 9) ? 6'($urandom) : flist[i];
            exp    = ref_ctrl(alu_op, funct);
            valid8 = (exp != 4'd7 && exp != 4'd8) ? 1'($urandom) : 1'b0;
            #1;
            checks++;
            if ({ctrl8, ill8, stall8, busy8} !== {exp, valid8 && exp == 4'd15, 2'b00}) begin
               errs++;
               $display("FAIL decode op=%b f=%b v=%b: ctrl/ill/stall/busy got %0d/%b/%b/%b want %0d/%b/0/0",
                        alu_op, funct, valid8, ctrl8, ill8, stall8, busy8, exp, valid8 && exp == 4'd15);
            end
         end
      end
      valid8 = 1'b0;
   endtask

   task automatic test_mult();
      run_op8(1'b0, 8'd200, 8'd150);
      checks++;
      if ({hi8, lo8} !== 16'h7530) begin
         errs++;
         $display("FAIL mult200x150: hi/lo got %h/%h want 75/30", hi8, lo8);
      end
      run_op8(1'b0, 8'hFF, 8'hFF);
      run_op8(1'b0, 8'd0, 8'($urandom));
      for (int i = 0; i < 5; i++) run_op8(1'b0, 8'($urandom), 8'($urandom));
   endtask

   task automatic test_div();
      run_op8(1'b1, 8'd200, 8'd7);
      run_op8(1'b1, 8'hFF, 8'd1);
      run_op8(1'b1, 8'd5, 8'd200);
      run_op8(1'b1, 8'($urandom), 8'd0);
      for (int i = 0; i < 5; i++) run_op8(1'b1, 8'($urandom), 8'($urandom_range(1, 255)));
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) run_op8(1'($urandom), 8'($urandom), 8'($urandom_range(0, 15)));
   endtask

   task automatic test_div0_32();
      @(negedge clk);
      alu_op  = 3'b100;
      funct   = 6'b011010;
      a32     = 32'h1234;
      b32     = 32'h0;
      valid32 = 1'b1;
      #1;
      checks++;
      if ({stall32, ill32} !== {DivEn, !DivEn}) begin
         errs++;
         $display("FAIL div0_32 issue: stall/ill got %b/%b want %b/%b", stall32, ill32, DivEn, !DivEn);
      end
      @(posedge clk);
      #1;
      a32 = $urandom;
      b32 = $urandom;
      @(negedge clk);
      if (DivEn) begin
         m32_hi = 32'h1234;
         m32_lo = 32'hFFFF_FFFF;
      end
      checks++;
      if ({busy32, done32, hi32, lo32} !== {DivEn, DivEn, m32_hi, m32_lo}) begin
         errs++;
         $display("FAIL div0_32 done: busy/done/hi/lo got %b/%b/%h/%h want %b/%b/%h/%h",
                  busy32, done32, hi32, lo32, DivEn, DivEn, m32_hi, m32_lo);
      end
      valid32 = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy32, done32, hi32, lo32} !== {2'b00, m32_hi, m32_lo}) begin
         errs++;
         $display("FAIL div0_32 idle: busy/done/hi/lo got %b/%b/%h/%h want 0/0/%h/%h",
                  busy32, done32, hi32, lo32, m32_hi, m32_lo);
      end
   endtask

   task automatic test_mul32();
      logic [31:0] a, b;
      logic [63:0] res;
      a   = $urandom;
      b   = $urandom;
      res = 64'(a) * 64'(b);
      @(negedge clk);
      alu_op  = 3'b100;
      funct   = 6'b011000;
      a32     = a;
      b32     = b;
      valid32 = 1'b1;
      @(posedge clk);
      #1;
      a32 = $urandom;
      b32 = $urandom;
      for (int k = 1; k <= 34; k++) begin
         @(negedge clk);
         if (k == 33) {m32_hi, m32_lo} = res;
         checks++;
         if ({busy32, done32, hi32, lo32} !== {k <= 33, k == 33, m32_hi, m32_lo}) begin
            errs++;
            $display("FAIL mul32 %h*%h cycle %0d: busy/done/hi/lo got %b/%b/%h/%h want %b/%b/%h/%h",
                     a, b, k, busy32, done32, hi32, lo32, k <= 33, k == 33, m32_hi, m32_lo);
         end
         if (k == 33) valid32 = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      alu_op = 3'b100;
      funct  = 6'b011000;
      a8     = 8'($urandom_range(1, 255));
      b8     = 8'($urandom_range(1, 255));
      valid8 = 1'b1;
      @(posedge clk);
      repeat (3) @(negedge clk);
      rst_n  = 1'b0;
      valid8 = 1'b0;
      #1;
      {m8_hi, m8_lo, m32_hi, m32_lo} = '0;
      checks++;
      if ({busy8, done8, stall8, hi8, lo8, busy32, hi32, lo32} !== '0) begin
         errs++;
         $display("FAIL reset_mid: busy/done/stall/hi/lo got %b/%b/%b/%h/%h busy32/hi32/lo32 %b/%h/%h want zeros",
                  busy8, done8, stall8, hi8, lo8, busy32, hi32, lo32);
      end
      @(negedge clk);
      checks++;
      if ({busy8, done8, hi8, lo8} !== '0) begin
         errs++;
         $display("FAIL reset_hold: busy/done/hi/lo got %b/%b/%h/%h want zeros", busy8, done8, hi8, lo8);
      end
      rst_n = 1'b1;
      run_op8(1'b0, 8'd3, 8'd5);
      checks++;
      if ({hi8, lo8} !== 16'd15) begin
         errs++;
         $display("FAIL mult3x5: hi/lo got %h/%h want 00/0f", hi8, lo8);
      end
   endtask

   task automatic test_div_then_mult();
      run_op8(1'b1, 8'($urandom), 8'($urandom_range(1, 255)));
      run_op8(1'b0, 8'd6, 8'd7);
      checks++;
      if ({hi8, lo8} !== 16'd42) begin
         errs++;
         $display("FAIL mult6x7: hi/lo got %h/%h want 00/2a", hi8, lo8);
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_mult();
      test_div();
      test_back_to_back();
      test_div0_32();
      test_mul32();
      test_reset_mid();
      test_div_then_mult();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
      $finish;
   end

endmodule
